// File: rtl/pmp_csr_regs_pkg.sv
// Shared definitions for the PMP CSR register file: CSR address map,
// cfg byte layout and A-field encodings.
package pmp_csr_regs_pkg;

    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
    localparam logic [11:0] PMPADDR_LAST = 12'h3EF;

    // Bit positions inside one cfg byte {L,2'b0,A[1:0],X,W,R}
    localparam int CFG_R_BIT = 0;
    localparam int CFG_W_BIT = 1;
    localparam int CFG_X_BIT = 2;
    localparam int CFG_A_LO  = 3;
    localparam int CFG_A_HI  = 4;
    localparam int CFG_L_BIT = 7;

    // Bits 6:5 are reserved and always stored as zero
    localparam logic [7:0] CFG_WARL_MASK = 8'h9F;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    // W=1 with R=0 is a reserved permission combination
    function automatic logic cfg_is_reserved(input logic [7:0] cfg);
        return cfg[CFG_W_BIT] & ~cfg[CFG_R_BIT];
    endfunction

endpackage

// File: rtl/pmp_csr_regs_cfg_byte_wr.sv
// One pmpcfg byte: WARL filtering and lock handling for a CSR write.
module pmp_cfg_byte_wr
    import pmp_csr_regs_pkg::*;
(
    input  pmp_cfg_t   old_i,
    input  logic [7:0] new_i,
    input  logic       wr_en_i,
    output pmp_cfg_t   next_o
);

    logic [7:0] cand_s;

    // Merge candidate byte into the stored byte unless locked or reserved.
    always_comb begin
        cand_s = new_i & CFG_WARL_MASK;
        next_o = old_i;
        if (wr_en_i && !old_i.l) begin
            if (cfg_is_reserved(cand_s)) begin
                next_o = old_i;
            end else begin
                next_o = pmp_cfg_t'(cand_s);
            end
        end else begin
            next_o = old_i;
        end
    end

endmodule

// File: rtl/pmp_csr_regs.sv
// PMP register file: pmpcfg/pmpaddr storage with WARL and lock rules,
// combinational CSR readback and a one-cycle change strobe.
module pmp_csr_regs
    import pmp_csr_regs_pkg::*;
#(
    parameter int PMP_ENTRIES = 16,
    parameter int XLEN        = 64,
    parameter int PA_BITS     = 56
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   CSRWriteM,
    input  logic [11:0]                                            CSRAdrM,
    input  logic [XLEN-1:0]                                        CSRWriteValM,
    output logic [XLEN-1:0]                                        CSRReadValM,
    output logic                                                   PMPCSRHitM,
    output logic [8*((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)-1:0]    PMPCFG_ARRAY_REGW,
    output logic [XLEN*((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)-1:0] PMPADDR_ARRAY_REGW,
    output logic                                                   PMPChangeM
);

    // Storage is kept at least one entry deep so a zero-entry build still
    // elaborates; the extra entry is tied to zero and never written.
    localparam int NE    = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
    localparam int AW    = PA_BITS - 2;
    localparam int BYTES = XLEN / 8;
    // Register-index stride: RV64 only uses even pmpcfg numbers
    localparam int CFG_STRIDE = XLEN / 32;

    pmp_cfg_t [NE-1:0]          cfg_q;
    pmp_cfg_t [NE-1:0]          cfg_d;
    logic     [NE-1:0][AW-1:0]  addr_q;
    logic     [NE-1:0][AW-1:0]  addr_d;
    logic                       change_q;
    logic                       change_d;

    logic        cfg_sel_s;
    logic        cfg_legal_s;
    logic        addr_sel_s;
    logic [3:0]  cfg_idx_s;
    logic [5:0]  addr_idx_s;

    assign cfg_sel_s   = (CSRAdrM[11:4] == PMPCFG_BASE[11:4]);
    assign cfg_idx_s   = CSRAdrM[3:0];
    assign cfg_legal_s = cfg_sel_s && ((XLEN == 32) || !cfg_idx_s[0]);
    assign addr_sel_s  = (CSRAdrM >= PMPADDR_BASE) && (CSRAdrM <= PMPADDR_LAST);
    // Low six address bits of 0x3B0..0x3EF minus 0x30 wrap to 0..63
    assign addr_idx_s  = CSRAdrM[5:0] - 6'h30;
    assign PMPCSRHitM  = cfg_legal_s || addr_sel_s;

    for (genvar i = 0; i < NE; i++) begin : g_ent
        localparam int CFG_REG  = (i / BYTES) * CFG_STRIDE;
        localparam int CFG_BYTE = i % BYTES;

        if (i < PMP_ENTRIES) begin : g_impl
            logic cfg_wr_s;
            logic addr_lock_s;
            logic addr_wr_s;

            assign cfg_wr_s = CSRWriteM && cfg_legal_s && (cfg_idx_s == 4'(CFG_REG));

            pmp_cfg_byte_wr u_cfg_byte (
                .old_i   (cfg_q[i]),
                .new_i   (CSRWriteValM[8*CFG_BYTE +: 8]),
                .wr_en_i (cfg_wr_s),
                .next_o  (cfg_d[i])
            );

            // An address is frozen by its own lock, or by the next entry
            // being a locked TOR region that uses it as its lower bound.
            if (i + 1 < PMP_ENTRIES) begin : g_tor
                assign addr_lock_s = cfg_q[i].l ||
                                     (cfg_q[i+1].l && (cfg_q[i+1].a == A_TOR));
            end else begin : g_last
                assign addr_lock_s = cfg_q[i].l;
            end

            assign addr_wr_s = CSRWriteM && addr_sel_s &&
                               (addr_idx_s == 6'(i)) && !addr_lock_s;
            assign addr_d[i] = addr_wr_s ? CSRWriteValM[AW-1:0] : addr_q[i];
        end else begin : g_unimpl
            assign cfg_d[i]  = pmp_cfg_t'(8'h00);
            assign addr_d[i] = {AW{1'b0}};
        end

        assign PMPCFG_ARRAY_REGW[8*i +: 8]     = cfg_q[i];
        assign PMPADDR_ARRAY_REGW[XLEN*i +: XLEN] = XLEN'(addr_q[i]);
    end

    // Any stored bit differing from its next value means the checker view moves.
    always_comb begin
        change_d = (cfg_d != cfg_q) || (addr_d != addr_q);
    end

    // Architectural state and change strobe; reset clears everything including L.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q    <= '0;
            addr_q   <= '0;
            change_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            addr_q   <= addr_d;
            change_q <= change_d;
        end
    end

    assign PMPChangeM = change_q;

    // Readback of the stored (not in-flight) value; unimplemented parts read 0.
    always_comb begin
        CSRReadValM = {XLEN{1'b0}};
        if (cfg_legal_s) begin
            for (int e = 0; e < PMP_ENTRIES; e++) begin
                if (cfg_idx_s == 4'((e / BYTES) * CFG_STRIDE)) begin
                    CSRReadValM[8*(e % BYTES) +: 8] = cfg_q[e];
                end else begin
                    CSRReadValM = CSRReadValM;
                end
            end
        end else if (addr_sel_s) begin
            for (int e = 0; e < PMP_ENTRIES; e++) begin
                if (addr_idx_s == 6'(e)) begin
                    CSRReadValM = XLEN'(addr_q[e]);
                end else begin
                    CSRReadValM = CSRReadValM;
                end
            end
        end else begin
            CSRReadValM = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_pmp_csr_regs.sv
// Directed self-checking bench for pmp_csr_regs (16 entries, XLEN=64, PA_BITS=56).
module tb_pmp_csr_regs;

    logic          clk;
    logic          reset;
    logic          CSRWriteM;
    logic [11:0]   CSRAdrM;
    logic [63:0]   CSRWriteValM;
    logic [63:0]   CSRReadValM;
    logic          PMPCSRHitM;
    logic [127:0]  PMPCFG_ARRAY_REGW;
    logic [1023:0] PMPADDR_ARRAY_REGW;
    logic          PMPChangeM;

    int checks = 0;
    int errors = 0;
    logic [63:0] rv;

    pmp_csr_regs #(.PMP_ENTRIES(16), .XLEN(64), .PA_BITS(56)) dut (
        .clk                (clk),
        .reset              (reset),
        .CSRWriteM          (CSRWriteM),
        .CSRAdrM            (CSRAdrM),
        .CSRWriteValM       (CSRWriteValM),
        .CSRReadValM        (CSRReadValM),
        .PMPCSRHitM         (PMPCSRHitM),
        .PMPCFG_ARRAY_REGW  (PMPCFG_ARRAY_REGW),
        .PMPADDR_ARRAY_REGW (PMPADDR_ARRAY_REGW),
        .PMPChangeM         (PMPChangeM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle write; returns at the negedge after the capturing posedge.
    task automatic do_wr(input logic [11:0] a, input logic [63:0] v);
        @(negedge clk);
        CSRWriteM    = 1'b1;
        CSRAdrM      = a;
        CSRWriteValM = v;
        @(negedge clk);
        CSRWriteM    = 1'b0;
        CSRWriteValM = 64'h0;
    endtask

    task automatic do_rd(input logic [11:0] a, output logic [63:0] v);
        @(negedge clk);
        CSRAdrM = a;
        #1;
        v = CSRReadValM;
    endtask

    initial begin
        reset        = 1'b1;
        CSRWriteM    = 1'b0;
        CSRAdrM      = 12'h000;
        CSRWriteValM = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_change", 128'(PMPChangeM), 128'h0);
        chk("rst_cfg_arr", PMPCFG_ARRAY_REGW, 128'h0);
        chk("rst_addr_arr", 128'(PMPADDR_ARRAY_REGW == 1024'h0), 128'h1);
        do_rd(12'h3A0, rv); chk("rst_rd_cfg0", 128'(rv), 128'h0);
        chk("hit_3a0", 128'(PMPCSRHitM), 128'h1);
        do_rd(12'h3B0, rv); chk("rst_rd_addr0", 128'(rv), 128'h0);

        // Plain cfg write, strobe for one cycle
        do_wr(12'h3A0, 64'h0000_0000_0000_001F);
        chk("cfg0_1f_change", 128'(PMPChangeM), 128'h1);
        chk("cfg0_1f_arr", 128'(PMPCFG_ARRAY_REGW[7:0]), 128'h1F);
        @(negedge clk);
        chk("change_drops", 128'(PMPChangeM), 128'h0);

        // Reserved W=1,R=0 keeps old byte, no strobe
        do_wr(12'h3A0, 64'h0000_0000_0000_00E2);
        chk("rsvd_change", 128'(PMPChangeM), 128'h0);
        chk("rsvd_arr", 128'(PMPCFG_ARRAY_REGW[7:0]), 128'h1F);

        // Bits 6:5 dropped: 0x6B -> 0x0B
        do_wr(12'h3A0, 64'h0000_0000_0000_006B);
        chk("mask65_change", 128'(PMPChangeM), 128'h1);
        do_rd(12'h3A0, rv); chk("mask65_rd", 128'(rv), 128'h0B);

        // cfg1 = L|TOR locks addr0 (TOR base) and addr1
        do_wr(12'h3A0, 64'h0000_0000_0000_8800);
        do_rd(12'h3A0, rv); chk("cfg1_lock_rd", 128'(rv), 128'h8800);
        do_wr(12'h3B0, 64'h1234);
        chk("addr0_tor_change", 128'(PMPChangeM), 128'h0);
        do_rd(12'h3B0, rv); chk("addr0_tor_rd", 128'(rv), 128'h0);
        do_wr(12'h3B1, 64'h1234);
        do_rd(12'h3B1, rv); chk("addr1_lock_rd", 128'(rv), 128'h0);
        do_wr(12'h3B2, 64'h1234);
        chk("addr2_change", 128'(PMPChangeM), 128'h1);
        do_rd(12'h3B2, rv); chk("addr2_rd", 128'(rv), 128'h1234);

        // Lock entry3, then try to clear whole word
        do_wr(12'h3A0, 64'h0000_0000_8000_8800);
        do_wr(12'h3A0, 64'h0000_0000_0000_0005);
        chk("lock3_change", 128'(PMPChangeM), 128'h1);
        do_rd(12'h3A0, rv); chk("lock3_rd", 128'(rv), 128'h8000_8805);
        do_wr(12'h3B3, 64'h77);
        do_rd(12'h3B3, rv); chk("addr3_lock_rd", 128'(rv), 128'h0);
        // L3 with A3=OFF does not freeze addr2
        do_wr(12'h3B2, 64'h55);
        do_rd(12'h3B2, rv); chk("addr2_off_rd", 128'(rv), 128'h55);
        do_wr(12'h3B2, 64'h55);
        chk("same_val_no_change", 128'(PMPChangeM), 128'h0);

        // Odd pmpcfg illegal on RV64
        do_wr(12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("odd_cfg_change", 128'(PMPChangeM), 128'h0);
        do_rd(12'h3A1, rv); chk("odd_cfg_rd", 128'(rv), 128'h0);
        chk("odd_cfg_hit", 128'(PMPCSRHitM), 128'h0);
        chk("odd_cfg_arr", PMPCFG_ARRAY_REGW, 128'h8000_8805);

        // Address truncated to PA_BITS-2 bits
        do_wr(12'h3B4, 64'hFFFF_FFFF_FFFF_FFFF);
        do_rd(12'h3B4, rv); chk("addr4_ones_rd", 128'(rv), 128'h003F_FFFF_FFFF_FFFF);
        chk("addr4_ones_arr", 128'(PMPADDR_ARRAY_REGW[4*64 +: 64]), 128'h003F_FFFF_FFFF_FFFF);

        // pmpcfg2 maps entries 8..15
        do_wr(12'h3A2, 64'h0F00_0000_0000_0019);
        do_rd(12'h3A2, rv); chk("cfg2_rd", 128'(rv), 128'h0F00_0000_0000_0019);
        chk("cfg2_arr8", 128'(PMPCFG_ARRAY_REGW[8*8 +: 8]), 128'h19);
        chk("cfg2_arr15", 128'(PMPCFG_ARRAY_REGW[15*8 +: 8]), 128'h0F);

        // Unimplemented entries and address decode edges
        do_wr(12'h3C4, 64'h5);
        chk("unimpl_change", 128'(PMPChangeM), 128'h0);
        do_rd(12'h3C4, rv); chk("unimpl_addr_rd", 128'(rv), 128'h0);
        chk("unimpl_addr_hit", 128'(PMPCSRHitM), 128'h1);
        do_rd(12'h3A4, rv); chk("unimpl_cfg_rd", 128'(rv), 128'h0);
        do_rd(12'h3EF, rv); chk("hit_3ef", 128'(PMPCSRHitM), 128'h1);
        do_rd(12'h3F0, rv); chk("hit_3f0", 128'(PMPCSRHitM), 128'h0);
        do_rd(12'h39F, rv); chk("hit_39f", 128'(PMPCSRHitM), 128'h0);

        // Back-to-back: lock entry4, next cycle write to addr4 is refused
        @(negedge clk);
        CSRWriteM    = 1'b1;
        CSRAdrM      = 12'h3A0;
        CSRWriteValM = 64'h0000_0088_8000_8805;
        @(negedge clk);
        CSRAdrM      = 12'h3B4;
        CSRWriteValM = 64'h0;
        chk("b2b_first_change", 128'(PMPChangeM), 128'h1);
        @(negedge clk);
        CSRWriteM    = 1'b0;
        chk("b2b_second_change", 128'(PMPChangeM), 128'h0);
        do_rd(12'h3B4, rv); chk("b2b_addr4_rd", 128'(rv), 128'h003F_FFFF_FFFF_FFFF);

        // Reset during a write clears locks and wins over the write
        @(negedge clk);
        CSRWriteM    = 1'b1;
        CSRAdrM      = 12'h3A0;
        CSRWriteValM = 64'h0000_0000_0000_001F;
        reset        = 1'b1;
        @(negedge clk);
        chk("midrst_cfg_arr", PMPCFG_ARRAY_REGW, 128'h0);
        chk("midrst_addr_arr", 128'(PMPADDR_ARRAY_REGW == 1024'h0), 128'h1);
        chk("midrst_change", 128'(PMPChangeM), 128'h0);
        CSRWriteM = 1'b0;
        reset     = 1'b0;
        do_wr(12'h3B1, 64'h99);
        do_rd(12'h3B1, rv); chk("post_rst_unlocked", 128'(rv), 128'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
